// File: rtl/sequence_detector_pkg.sv
// Shared constants and state type for the 3-bit symbol sequence detector.
// The target sequence and the expected-symbol lookup are both defined here.
package sequence_detector_pkg;

  localparam int unsigned SYM_W   = 3;
  localparam int unsigned SEQ_LEN = 8;

  typedef logic [SYM_W-1:0] sym_t;

  localparam sym_t SEQ [SEQ_LEN] = '{
    3'b001, 3'b101, 3'b110, 3'b000,
    3'b110, 3'b110, 3'b011, 3'b101
  };

  // Encodings are consecutive so that advancing a match is state + 1.
  typedef enum logic [3:0] {
    IDLE  = 4'd0,
    M1    = 4'd1,
    M2    = 4'd2,
    M3    = 4'd3,
    M4    = 4'd4,
    M5    = 4'd5,
    M6    = 4'd6,
    M7    = 4'd7,
    FOUND = 4'd8
  } state_t;

  function automatic sym_t expected_sym(input state_t s);
    case (s)
      IDLE:    return SEQ[0];
      M1:      return SEQ[1];
      M2:      return SEQ[2];
      M3:      return SEQ[3];
      M4:      return SEQ[4];
      M5:      return SEQ[5];
      M6:      return SEQ[6];
      M7:      return SEQ[7];
      default: return SEQ[0];
    endcase
  endfunction

endpackage

// File: rtl/sequence_detector.sv
// Moore FSM that flags, for one cycle, the fixed eight-symbol sequence
// on a free-running 3-bit symbol bus.
module sequence_detector
  import sequence_detector_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic [SYM_W-1:0] data,
  output logic             sequence_found
);

  state_t state;
  state_t state_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // 001 occurs only at the head of the sequence, so any mismatch either
  // restarts at M1 (on 001) or falls back to IDLE.
  always_comb begin
    state_nxt = IDLE;
    if ((state != FOUND) && (data == expected_sym(state))) begin
      state_nxt = state_t'(state + 4'd1);
    end else if (data == SEQ[0]) begin
      state_nxt = M1;
    end
  end

  assign sequence_found = (state == FOUND);

endmodule

// File: tb/tb_sequence_detector.sv
// Bench for sequence_detector: directed scenarios followed by randomized
// symbol streams, checked against a sliding-window reference model.
module tb_sequence_detector;

  logic       clk;
  logic       rst_n;
  logic [2:0] data;
  logic       sequence_found;

  int unsigned vectors;
  int unsigned miscompares;

  logic [2:0] ref_seq [8] = '{3'b001, 3'b101, 3'b110, 3'b000,
                              3'b110, 3'b110, 3'b011, 3'b101};
  // Symbols received since the last reset, newest at the back, at most 8 kept.
  logic [2:0] window [$];

  sequence_detector dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .data           (data),
    .sequence_found (sequence_found)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic observed, input logic expected);
    vectors++;
    assert (observed === expected)
    else begin
      miscompares++;
      $error("FAIL %s observed=%b expected=%b at %0t", tag, observed, expected, $time);
    end
  endtask

  function automatic logic model_found();
    if (window.size() != 8) return 1'b0;
    for (int i = 0; i < 8; i++)
      if (window[i] !== ref_seq[i]) return 1'b0;
    return 1'b1;
  endfunction

  // Drive one symbol, let the next rising edge sample it, then compare.
  task automatic apply(input logic [2:0] s, input string tag);
    data = s;
    @(posedge clk);
    #1;
    window.push_back(s);
    if (window.size() > 8) void'(window.pop_front());
    check(tag, sequence_found, model_found());
  endtask

  task automatic apply_seq(input string tag);
    for (int i = 0; i < 8; i++) apply(ref_seq[i], tag);
  endtask

  task automatic do_reset(input int unsigned cycles);
    rst_n = 1'b0;
    data  = 3'bxxx;
    window.delete();
    #1;
    check("reset_async", sequence_found, 1'b0);
    repeat (cycles) @(posedge clk);
    #1;
    check("reset_hold", sequence_found, 1'b0);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [2:0] stream [$];
    int unsigned kind;
    int unsigned pos;
    int unsigned pulses;

    vectors     = 0;
    miscompares = 0;
    pulses      = 0;
    rst_n       = 1'b0;
    data        = 3'b000;
    #1;
    check("reset_initial", sequence_found, 1'b0);
    do_reset(2);

    // Clean detection followed by a non-matching symbol.
    apply_seq("clean");
    check("clean_pulse", sequence_found, 1'b1);
    apply(3'b000, "clean_after");
    check("clean_drop", sequence_found, 1'b0);

    // Back-to-back: two pulses 8 cycles apart.
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < 8; i++) begin
        apply(ref_seq[i], "b2b");
        if (sequence_found === 1'b1) pulses++;
      end
    end
    vectors++;
    assert (pulses == 2)
    else begin
      miscompares++;
      $error("FAIL b2b_count observed=%0d expected=2", pulses);
    end
    apply(3'b111, "b2b_after");

    // Mismatching 001 restarts the match at M1.
    apply(3'b001, "restart");
    apply(3'b101, "restart");
    apply_seq("restart");
    check("restart_pulse", sequence_found, 1'b1);

    // Broken sequence: no pulse anywhere.
    stream = '{3'b001, 3'b101, 3'b110, 3'b111, 3'b110, 3'b110, 3'b011, 3'b101};
    foreach (stream[i]) apply(stream[i], "broken");
    check("broken_nopulse", sequence_found, 1'b0);

    // Reset mid-sequence discards progress.
    for (int i = 0; i < 4; i++) apply(ref_seq[i], "midrst_head");
    do_reset(2);
    for (int i = 4; i < 8; i++) apply(ref_seq[i], "midrst_tail");
    check("midrst_nopulse", sequence_found, 1'b0);
    apply_seq("midrst_full");
    check("midrst_pulse", sequence_found, 1'b1);

    // Asynchronous reset while in FOUND drops the flag before the next edge.
    #2;
    rst_n = 1'b0;
    #1;
    check("found_async_drop", sequence_found, 1'b0);
    do_reset(1);

    // Randomized streams mixing full, corrupted and random segments.
    for (int n = 0; n < 60; n++) begin
      kind = $urandom_range(0, 9);
      if (kind < 4) begin
        apply_seq("rand_full");
      end else if (kind < 7) begin
        pos = $urandom_range(0, 7);
        for (int i = 0; i < 8; i++)
          apply((i == int'(pos)) ? 3'($urandom_range(0, 7)) : ref_seq[i], "rand_corrupt");
      end else if (kind < 9) begin
        for (int i = 0; i < int'($urandom_range(1, 6)); i++)
          apply(3'($urandom_range(0, 7)), "rand_noise");
      end else begin
        do_reset($urandom_range(1, 3));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
